// File: rtl/conv_mem_scheduler.sv
// Conv data memory <-> NoC memory-node sequencer: streams filter/ifmap rows, collects results.
// Optional SCHED_RESULT_SUM_EN adds a result_sum output accumulating accepted results.
module conv_mem_scheduler #(
    parameter int          DWIDTH      = 8,
    parameter int          PWIDTH      = 47,
    parameter int          AWIDTH      = 8,
    parameter int          FILT_BASE   = 0,
    parameter int          PIX_BASE    = 9,
    parameter int          NUM_RESULTS = 9,
    parameter int          RES_BASE    = 200,
    parameter logic [2:0]  SRC_ADDR    = 3'b110
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_rd_addr,
    input  logic [DWIDTH-1:0] mem_rd_data,
    output logic [PWIDTH-1:0] pkt_out,
    output logic              pkt_out_valid,
    input  logic              pkt_out_ready,
    input  logic [PWIDTH-1:0] pkt_in,
    input  logic              pkt_in_valid,
    output logic              pkt_in_ready,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_wr_addr,
    output logic [DWIDTH-1:0] mem_wr_data
`ifdef SCHED_RESULT_SUM_EN
    ,
    output logic [DWIDTH+3:0] result_sum
`endif
);

    localparam int RW   = 5 * DWIDTH;
    localparam int FPW  = RW - 3 * DWIDTH;
    localparam int CNTW = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam logic [FPW-1:0]    FPAD  = FPW'(16'h00FF);
    localparam logic [CNTW-1:0]   RLAST = CNTW'(NUM_RESULTS - 1);
    localparam logic [AWIDTH-1:0] FBASE = AWIDTH'(FILT_BASE);
    localparam logic [AWIDTH-1:0] PBASE = AWIDTH'(PIX_BASE);
    localparam logic [AWIDTH-1:0] RBASE = AWIDTH'(RES_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_RD,
        S_F_SEND,
        S_P_RD,
        S_P_SEND,
        S_RES_WAIT,
        S_RES_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [2:0]        row_q, row_d;
    logic [1:0]        pe_q, pe_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]     data_q, data_d;
    logic [CNTW-1:0]   rcnt_q, rcnt_d;
    logic [DWIDTH-1:0] res_q [NUM_RESULTS];
    logic [DWIDTH-1:0] res_d [NUM_RESULTS];
`ifdef SCHED_RESULT_SUM_EN
    logic [DWIDTH+3:0] sum_q, sum_d;
`endif

    logic [2:0] wlen;
    logic [2:0] dest;
    logic [1:0] pe_nxt;
    logic       unused_pkt_in;

    assign unused_pkt_in = ^pkt_in[PWIDTH-1:DWIDTH];

    always_comb begin
        dest = 3'b011;
        unique case (1'b1)
            (pe_q == 2'd1): dest = 3'b001;
            (pe_q == 2'd2): dest = 3'b000;
            default:        dest = 3'b011;
        endcase
    end

    assign pe_nxt = (pe_q == 2'd2) ? 2'd0 : pe_q + 2'd1;
    assign wlen   = (state_q == S_F_RD) ? 3'd3 : 3'd5;

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        row_d         = row_q;
        pe_d          = pe_q;
        rd_ptr_d      = rd_ptr_q;
        data_d        = data_q;
        rcnt_d        = rcnt_q;
        res_d         = res_q;
`ifdef SCHED_RESULT_SUM_EN
        sum_d         = sum_q;
`endif
        busy          = 1'b0;
        done          = 1'b0;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = '0;
        pkt_out       = '0;
        pkt_out_valid = 1'b0;
        pkt_in_ready  = 1'b0;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_F_RD;
                    bcnt_d   = '0;
                    row_d    = '0;
                    pe_d     = '0;
                    rd_ptr_d = FBASE;
                    data_d   = '0;
                    rcnt_d   = '0;
`ifdef SCHED_RESULT_SUM_EN
                    sum_d    = '0;
`endif
                end
            end

            S_F_RD, S_P_RD: begin
                busy = 1'b1;
                // Byte read at step n arrives at step n+1; shifted in MSB-first.
                if (bcnt_q != 3'd0) begin
                    data_d = {data_q[RW-DWIDTH-1:0], mem_rd_data};
                end
                if (bcnt_q < wlen) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = rd_ptr_q;
                    rd_ptr_d    = rd_ptr_q + AWIDTH'(1);
                end
                if (bcnt_q == wlen) begin
                    state_d = (state_q == S_F_RD) ? S_F_SEND : S_P_SEND;
                end else begin
                    bcnt_d = bcnt_q + 3'd1;
                end
            end

            S_F_SEND: begin
                busy          = 1'b1;
                pkt_out_valid = 1'b1;
                pkt_out       = {1'b0, dest, SRC_ADDR, FPAD,
                                 data_q[3*DWIDTH-1:0]};
                if (pkt_out_ready) begin
                    bcnt_d = '0;
                    if (row_q == 3'd2) begin
                        state_d  = S_P_RD;
                        row_d    = '0;
                        pe_d     = '0;
                        rd_ptr_d = PBASE;
                    end else begin
                        state_d = S_F_RD;
                        row_d   = row_q + 3'd1;
                        pe_d    = pe_nxt;
                    end
                end
            end

            S_P_SEND: begin
                busy          = 1'b1;
                pkt_out_valid = 1'b1;
                pkt_out       = {1'b1, dest, SRC_ADDR, data_q};
                if (pkt_out_ready) begin
                    bcnt_d = '0;
                    if (row_q == 3'd4) begin
                        state_d = S_RES_WAIT;
                        rcnt_d  = '0;
                    end else begin
                        state_d = S_P_RD;
                        row_d   = row_q + 3'd1;
                        pe_d    = pe_nxt;
                    end
                end
            end

            S_RES_WAIT: begin
                busy         = 1'b1;
                pkt_in_ready = 1'b1;
                if (pkt_in_valid) begin
                    res_d[rcnt_q] = pkt_in[DWIDTH-1:0];
`ifdef SCHED_RESULT_SUM_EN
                    sum_d = sum_q + (DWIDTH+4)'(pkt_in[DWIDTH-1:0]);
`endif
                    if (rcnt_q == RLAST) begin
                        state_d = S_RES_WR;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + CNTW'(1);
                    end
                end
            end

            S_RES_WR: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_addr = RBASE + AWIDTH'(rcnt_q);
                mem_wr_data = res_q[rcnt_q];
                if (rcnt_q == RLAST) begin
                    state_d = S_DONE;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + CNTW'(1);
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            row_q    <= '0;
            pe_q     <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            rcnt_q   <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                res_q[i] <= '0;
            end
`ifdef SCHED_RESULT_SUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            row_q    <= row_d;
            pe_q     <= pe_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            rcnt_q   <= rcnt_d;
            res_q    <= res_d;
`ifdef SCHED_RESULT_SUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

`ifdef SCHED_RESULT_SUM_EN
    assign result_sum = sum_q;
`endif

endmodule

// File: tb/tb_conv_mem_scheduler.sv
// Directed bench for conv_mem_scheduler: packet streams, stall, results, abort, ignored inputs.
module tb_conv_mem_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [46:0] pkt_out;
    logic        pkt_out_valid;
    logic        pkt_out_ready;
    logic [46:0] pkt_in;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [7:0]  mem_wr_data;
`ifdef SCHED_RESULT_SUM_EN
    logic [11:0] result_sum;
    logic [11:0] sum_at_done;
`endif

    conv_mem_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .pkt_out      (pkt_out),
        .pkt_out_valid(pkt_out_valid),
        .pkt_out_ready(pkt_out_ready),
        .pkt_in       (pkt_in),
        .pkt_in_valid (pkt_in_valid),
        .pkt_in_ready (pkt_in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
`ifdef SCHED_RESULT_SUM_EN
        ,
        .result_sum   (result_sum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [256];
    logic [46:0] exp_pkt [8];
    logic [46:0] pkts [$];
    logic [7:0]  wr_a [$];
    logic [7:0]  wr_d [$];
    int rd_cnt;
    int done_cnt;
    int db_viol;
    int early_rdy;
    int inj_to;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(negedge clk) begin
        if (pkt_out_valid && pkt_out_ready) pkts.push_back(pkt_out);
        if (mem_wr_en) begin
            wr_a.push_back(mem_wr_addr);
            wr_d.push_back(mem_wr_data);
        end
        if (mem_rd_en) rd_cnt++;
        if (pkt_in_ready && pkts.size() < 8) early_rdy++;
        if (done) begin
            done_cnt++;
            if (busy) db_viol++;
`ifdef SCHED_RESULT_SUM_EN
            sum_at_done = result_sum;
`endif
        end
    end

    task automatic clear_logs();
        pkts.delete();
        wr_a.delete();
        wr_d.delete();
        rd_cnt = 0;
        done_cnt = 0;
        db_viol = 0;
        early_rdy = 0;
        inj_to = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic inject_results(input bit first_pending);
        bit acc;
        for (int i = 0; i < 9; i++) begin
            if (!(first_pending && i == 0)) begin
                pkt_in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                pkt_in = {39'h2A, 8'(5 + i)};
                pkt_in_valid = 1'b1;
            end
            acc = 1'b0;
            for (int c = 0; c < 1000 && !acc; c++) begin
                @(negedge clk);
                acc = pkt_in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                inj_to++;
                break;
            end
        end
        pkt_in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) ok = 1'b1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pkt_out_ready = 1'b1;
        pkt_in_valid = 1'b0;
        pkt_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, pkt_out_valid, pkt_in_ready, mem_wr_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {busy, done, mem_rd_en, pkt_out_valid, pkt_in_ready, mem_wr_en});
        end
        checks++;
        if ({pkt_out, mem_rd_addr, mem_wr_addr, mem_wr_data} !== 71'b0) begin
            failures++;
            $display("FAIL reset_data got pkt=%h ra=%h wa=%h wd=%h want 0",
                     pkt_out, mem_rd_addr, mem_wr_addr, mem_wr_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_full_pass();
        bit ok;
        clear_logs();
        pkt_out_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b want=1", busy);
        end
        inject_results(0);
        wait_done(ok);
        checks++;
        if (!ok || inj_to != 0) begin
            failures++;
            $display("FAIL full_timeout done=%0d inj_to=%0d want done", ok, inj_to);
        end
        checks++;
        if (pkts.size() != 8) begin
            failures++;
            $display("FAIL full_pkt_count got=%0d want=8", pkts.size());
        end else begin
            checks++;
            if (pkts[0] !== 47'h1E00FF010203) begin
                failures++;
                $display("FAIL first_filt got=%h want=1e00ff010203", pkts[0]);
            end
            checks++;
            if (pkts[3] !== 47'h5E1011121314) begin
                failures++;
                $display("FAIL first_pix got=%h want=5e1011121314", pkts[3]);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (pkts[k] !== exp_pkt[k]) begin
                    failures++;
                    $display("FAIL full_pkt%0d got=%h want=%h", k, pkts[k], exp_pkt[k]);
                end
            end
        end
        checks++;
        if (rd_cnt != 34) begin
            failures++;
            $display("FAIL full_reads got=%0d want=34", rd_cnt);
        end
        checks++;
        if (wr_a.size() != 9) begin
            failures++;
            $display("FAIL full_wr_count got=%0d want=9", wr_a.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_a[i] !== 8'(200 + i) || wr_d[i] !== 8'(5 + i)) begin
                    failures++;
                    $display("FAIL full_wr%0d got=%0d:%0d want=%0d:%0d",
                             i, wr_a[i], wr_d[i], 200 + i, 5 + i);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || db_viol != 0) begin
            failures++;
            $display("FAIL done_pulse got cnt=%0d busyhi=%0d want 1/0", done_cnt, db_viol);
        end
`ifdef SCHED_RESULT_SUM_EN
        checks++;
        if (sum_at_done !== 12'd81) begin
            failures++;
            $display("FAIL result_sum got=%0d want=81", sum_at_done);
        end
`endif
    endtask

    task automatic test_stall();
        bit ok;
        logic [46:0] hold;
        int bad;
        int rd0;
        clear_logs();
        pkt_out_ready = 1'b1;
        hold = '0;
        bad = 0;
        pulse_start();
        fork
            inject_results(0);
            begin
                for (int c = 0; c < 200 && pkts.size() < 1; c++) begin
                    @(posedge clk); #1;
                end
                pkt_out_ready = 1'b0;
                for (int c = 0; c < 200 && !pkt_out_valid; c++) begin
                    @(posedge clk); #1;
                end
                hold = pkt_out;
                rd0 = rd_cnt;
                repeat (10) begin
                    @(negedge clk);
                    if (pkt_out !== hold || mem_rd_en || !pkt_out_valid) bad++;
                end
                checks++;
                if (bad != 0 || rd_cnt != rd0) begin
                    failures++;
                    $display("FAIL stall_hold got bad=%0d reads=%0d want 0/0",
                             bad, rd_cnt - rd0);
                end
                @(posedge clk); #1;
                pkt_out_ready = 1'b1;
            end
        join
        wait_done(ok);
        checks++;
        if (hold !== exp_pkt[1]) begin
            failures++;
            $display("FAIL stall_pkt got=%h want=%h", hold, exp_pkt[1]);
        end
        checks++;
        if (!ok || pkts.size() != 8 || rd_cnt != 34) begin
            failures++;
            $display("FAIL stall_pass got done=%0d pkts=%0d reads=%0d want 1/8/34",
                     ok, pkts.size(), rd_cnt);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (pkts[k] !== exp_pkt[k]) begin
                    failures++;
                    $display("FAIL stall_pkt%0d got=%h want=%h", k, pkts[k], exp_pkt[k]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int rd0;
        clear_logs();
        pkt_out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 300 && pkts.size() < 3; c++) begin
            @(posedge clk); #1;
        end
        pkt_out_ready = 1'b0;
        for (int c = 0; c < 300 && !pkt_out_valid; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pkt_out_valid !== 1'b1 || pkt_out[46] !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_psend got v=%b t=%b want 1/1", pkt_out_valid, pkt_out[46]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        rd0 = rd_cnt;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, pkt_out_valid, pkt_in_ready, mem_wr_en} !== 6'b0 ||
            pkt_out !== 47'b0 || mem_rd_addr !== 8'b0 || mem_wr_addr !== 8'b0) begin
            failures++;
            $display("FAIL abort_outputs got ctl=%b pkt=%h want 0",
                     {busy, done, mem_rd_en, pkt_out_valid, pkt_in_ready, mem_wr_en}, pkt_out);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pkt_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt != rd0 || pkts.size() != 3 || wr_a.size() != 0) begin
            failures++;
            $display("FAIL abort_quiet got reads=%0d pkts=%0d wrs=%0d want 0/3/0",
                     rd_cnt - rd0, pkts.size(), wr_a.size());
        end
        clear_logs();
        pulse_start();
        inject_results(0);
        wait_done(ok);
        checks++;
        if (!ok || pkts.size() != 8 || wr_a.size() != 9) begin
            failures++;
            $display("FAIL rerun_pass got done=%0d pkts=%0d wrs=%0d want 1/8/9",
                     ok, pkts.size(), wr_a.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (pkts[k] !== exp_pkt[k]) begin
                    failures++;
                    $display("FAIL rerun_pkt%0d got=%h want=%h", k, pkts[k], exp_pkt[k]);
                end
            end
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        clear_logs();
        pkt_out_ready = 1'b1;
        pulse_start();
        pkt_in = {39'h2A, 8'd5};
        pkt_in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inject_results(1);
        wait_done(ok);
        checks++;
        if (early_rdy != 0) begin
            failures++;
            $display("FAIL early_ready got=%0d want=0", early_rdy);
        end
        checks++;
        if (!ok || rd_cnt != 34 || pkts.size() != 8 || done_cnt != 1) begin
            failures++;
            $display("FAIL ignore_pass got done=%0d reads=%0d pkts=%0d dones=%0d want 1/34/8/1",
                     ok, rd_cnt, pkts.size(), done_cnt);
        end
        checks++;
        if (wr_d.size() != 9) begin
            failures++;
            $display("FAIL ignore_wr_count got=%0d want=9", wr_d.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_a[i] !== 8'(200 + i) || wr_d[i] !== 8'(5 + i)) begin
                    failures++;
                    $display("FAIL ignore_wr%0d got=%0d:%0d want=%0d:%0d",
                             i, wr_a[i], wr_d[i], 200 + i, 5 + i);
                end
            end
        end
    endtask

    initial begin
        logic [2:0] dst [5];
        dst = '{3'b011, 3'b001, 3'b000, 3'b011, 3'b001};
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
        for (int i = 9; i < 34; i++) mem[i] = 8'(8'h10 + i - 9);
        for (int k = 0; k < 3; k++) begin
            exp_pkt[k] = {1'b0, dst[k], 3'b110, 16'h00FF,
                          mem[3*k], mem[3*k+1], mem[3*k+2]};
        end
        for (int r = 0; r < 5; r++) begin
            exp_pkt[3+r] = {1'b1, dst[r], 3'b110, mem[9+5*r], mem[10+5*r],
                            mem[11+5*r], mem[12+5*r], mem[13+5*r]};
        end
        clear_logs();
        test_reset();
        test_full_pass();
        test_stall();
        test_reset_abort();
        test_ignored_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
